// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory controller: access size
// encodings, controller state type and the per-size alignment mask.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT2 = 2'b01,
    RESP  = 2'b10
  } state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SZ_BYTE: mask = 3'b000;
      SZ_HALF: mask = 3'b001;
      SZ_WORD: mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with a 4-byte big-endian write port (lane 3 lands at the
// base address) and a registered 4-byte read port; lane addresses wrap.
module dmem_byte_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];
  logic [31:0]       rdata_q;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = addr_i + ADDR_W'(k);
    end
  end

  // NOTE: storage has no reset; contents survive reset and only the
  // controller's control/status registers are cleared.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[3-k]) begin
        mem_q[lane_addr[k]] <= wdata_i[31-8*k -: 8];
      end
    end
    if (re_i) begin
      rdata_q <= {mem_q[lane_addr[0]], mem_q[lane_addr[1]],
                  mem_q[lane_addr[2]], mem_q[lane_addr[3]]};
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Registered-read MEM-stage data memory with req/done handshake and two-beat
// doubleword support. Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter bit DBL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              se,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [63:0]       rdata
);

  state_e            state_q, state_d;
  logic              accept, illegal_sz, misaligned, bad_req;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q, se_q, err_q;
  logic [1:0]        size_q;
  logic [31:0]       wlo_q, hi_q;
  logic [63:0]       rdata_q, rdata_fmt;

  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_re;

  assign accept     = (state_q == IDLE) && req && !reset;
  assign illegal_sz = (size == SZ_DBL) && !DBL_EN;
`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |(addr[2:0] & align_mask(size));
`else
  assign misaligned = 1'b0;
`endif
  assign bad_req = illegal_sz | misaligned;

  dmem_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

  // Beat 2 replays the registered request at addr+4; otherwise the live
  // request drives the array so the access happens on the accepting edge.
  always_comb begin
    mem_addr  = addr;
    mem_we    = 4'h0;
    mem_wdata = wdata[31:0];
    mem_re    = 1'b0;
    if (state_q == BEAT2) begin
      mem_addr  = addr_q + ADDR_W'(4);
      mem_we    = (rw_q && !reset) ? 4'hF : 4'h0;
      mem_wdata = wlo_q;
      mem_re    = !rw_q;
    end else if (accept) begin
      mem_re = !rw;
      if (rw && !bad_req) begin
        case (size)
          SZ_BYTE: begin mem_we = 4'b1000; mem_wdata = {wdata[7:0], 24'h0};  end
          SZ_HALF: begin mem_we = 4'b1100; mem_wdata = {wdata[15:0], 16'h0}; end
          SZ_WORD: begin mem_we = 4'b1111; mem_wdata = wdata[31:0];          end
          default: begin mem_we = 4'b1111; mem_wdata = wdata[63:32];         end
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (size == SZ_DBL && !bad_req) ? BEAT2 : RESP;
      BEAT2:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_fmt = 64'h0;
    if (!err_q && !rw_q) begin
      case (size_q)
        SZ_BYTE: rdata_fmt = {32'h0, {24{se_q & mem_rdata[31]}}, mem_rdata[31:24]};
        SZ_HALF: rdata_fmt = {32'h0, {16{se_q & mem_rdata[31]}}, mem_rdata[31:16]};
        SZ_WORD: rdata_fmt = {32'h0, mem_rdata};
        default: rdata_fmt = {hi_q, mem_rdata};
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == RESP);
  assign err   = done && err_q;
  assign rdata = done ? rdata_fmt : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= 64'h0;
    end else begin
      state_q <= state_d;
      if (accept) err_q <= bad_req;
      if (state_q == RESP) rdata_q <= rdata_fmt;
    end
  end

  // Request fields are only consumed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr;
      rw_q   <= rw;
      size_q <= size;
      se_q   <= se;
      wlo_q  <= wdata[31:0];
    end
    if (state_q == BEAT2) hi_q <= mem_rdata;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl against a byte-array reference model.
// Honours DMEM_ALIGN_CHECK_EN when deciding expected err for misaligned accesses.
module tb_dmem_ctrl;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam bit DBL_EN = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              rw = 1'b0;
  logic [1:0]        size = 2'b00;
  logic              se = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [63:0]       wdata = '0;
  logic              ready, done, err;
  logic [63:0]       rdata;

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_mem [DEPTH];

  dmem_ctrl #(.ADDR_W(ADDR_W), .DBL_EN(DBL_EN)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .rw    (rw),
    .size  (size),
    .se    (se),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .err   (err),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
    bit illegal = (sz == 2'b11) && !DBL_EN;
    bit mis     = ALIGN_CHK && ((int'(a) % nbytes(sz)) != 0);
    return illegal || mis;
  endfunction

  function automatic logic [63:0] model_load(input logic [1:0] sz, input logic s,
                                             input logic [ADDR_W-1:0] a);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < nbytes(sz); i++) v = (v << 8) | 64'(ref_mem[(int'(a) + i) % DEPTH]);
    if (sz == 2'b00 && s && v[7])  v = v | 64'hFFFF_FF00;
    if (sz == 2'b01 && s && v[15]) v = v | 64'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                             input logic [63:0] wd, input int nb);
    int n = nbytes(sz);
    for (int i = 0; i < nb; i++) ref_mem[(int'(a) + i) % DEPTH] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  // One complete access from IDLE; checks latency, handshake and result.
  task automatic access(input logic rw_v, input logic [1:0] sz, input logic se_v,
                        input logic [ADDR_W-1:0] a, input logic [63:0] wd);
    bit          e   = model_err(sz, a);
    int          lat = (sz == 2'b11 && !e) ? 2 : 1;
    logic [63:0] exp_rd = 64'h0;
    if (!rw_v && !e) exp_rd = model_load(sz, se_v, a);
    if (rw_v && !e) model_store(sz, a, wd, nbytes(sz));
    check("ready_before_accept", 64'(ready), 64'd1);
    req = 1'b1; rw = rw_v; size = sz; se = se_v; addr = a; wdata = wd;
    tick();
    req = 1'b0;
    wdata = {$urandom, $urandom};
    for (int k = 1; k < lat; k++) begin
      check("beat2_ready", 64'(ready), 64'd0);
      check("beat2_done", 64'(done), 64'd0);
      tick();
    end
    check("resp_done", 64'(done), 64'd1);
    check("resp_ready", 64'(ready), 64'd0);
    check("resp_err", 64'(err), 64'(e));
    if (!rw_v || e) check("resp_rdata", rdata, exp_rd);
    tick();
    check("after_done", 64'(done), 64'd0);
    check("after_err", 64'(err), 64'd0);
    check("after_ready", 64'(ready), 64'd1);
    if (!rw_v) check("rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    int n_done;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_rdata", rdata, 64'd0);

    // Fill the whole array so every later load is defined.
    for (int w = 0; w < DEPTH; w += 4) access(1'b1, 2'b10, 1'b0, ADDR_W'(w), {32'h0, $urandom});

    access(1'b1, 2'b10, 1'b0, 9'h010, 64'hDEADBEEF);
    access(1'b0, 2'b10, 1'b0, 9'h010, 64'h0);
    check("word_value", rdata, 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 4; i++) access(1'b0, 2'b00, 1'b0, ADDR_W'(9'h010 + i), 64'h0);

    access(1'b1, 2'b00, 1'b0, 9'h020, 64'h80);
    access(1'b0, 2'b00, 1'b1, 9'h020, 64'h0);
    check("byte_sext", rdata, 64'h0000_0000_FFFF_FF80);
    access(1'b0, 2'b00, 1'b0, 9'h020, 64'h0);
    check("byte_zext", rdata, 64'h0000_0000_0000_0080);
    access(1'b1, 2'b01, 1'b0, 9'h022, 64'h8001);
    access(1'b0, 2'b01, 1'b1, 9'h022, 64'h0);
    check("half_sext", rdata, 64'h0000_0000_FFFF_8001);
    access(1'b0, 2'b01, 1'b0, 9'h022, 64'h0);

    access(1'b1, 2'b11, 1'b0, 9'h040, 64'h1122334455667788);
    access(1'b0, 2'b11, 1'b0, 9'h040, 64'h0);
    check("dbl_value", rdata, 64'h1122334455667788);

    access(1'b1, 2'b10, 1'b0, 9'h041, 64'hCAFEF00D);
    access(1'b0, 2'b10, 1'b0, 9'h040, 64'h0);
    access(1'b0, 2'b10, 1'b0, 9'h044, 64'h0);

    // Reset during beat 2 of a doubleword store.
    req = 1'b1; rw = 1'b1; size = 2'b11; se = 1'b0; addr = 9'h080;
    wdata = 64'hA1A2A3A4_B1B2B3B4;
    tick();
    model_store(2'b11, 9'h080, 64'hA1A2A3A4_B1B2B3B4, 4);
    req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    tick();
    check("abort_no_late_done", 64'(done), 64'd0);
    access(1'b0, 2'b10, 1'b0, 9'h080, 64'h0);
    check("abort_beat1_written", rdata, 64'h0000_0000_A1A2_A3A4);
    access(1'b0, 2'b10, 1'b0, 9'h084, 64'h0);

    // Held request: one accept per 2 cycles (3 for doubleword).
    req = 1'b1; rw = 1'b0; size = 2'b10; addr = 9'h010; se = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (done) n_done++; end
    req = 1'b0;
    check("b2b_word_dones", 64'(n_done), 64'd10);
    check("b2b_word_idle", 64'(ready), 64'd1);
    req = 1'b1; size = 2'b11; addr = 9'h040;
    n_done = 0;
    for (int i = 0; i < 21; i++) begin tick(); if (done) n_done++; end
    req = 1'b0;
    check("b2b_dbl_dones", 64'(n_done), 64'd7);
    check("b2b_dbl_idle", 64'(ready), 64'd1);

    for (int t = 0; t < 300; t++) begin
      access(1'($urandom), 2'($urandom), 1'($urandom), ADDR_W'($urandom), {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
